// File: rtl/membus_lsu_pkg.sv
// Shared types for the load/store unit: bus payloads, access sizes and FSM states.
package membus_lsu_pkg;

    typedef logic [31:0] uint32;

    typedef struct packed {
        uint32      write_data;
        logic [3:0] mask_byte;
    } membus_cmd_t;

    typedef struct packed {
        uint32 read_data;
    } membus_res_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } access_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRST,
        ST_SECOND,
        ST_WAIT,
        ST_DONE
    } lsu_state_e;

    function automatic logic [2:0] byte_count(input access_size_e size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/membus_lsu_align.sv
// Combinational lane logic: byte mask, shifted write data, read extract and extend.
module membus_lsu_align
    import membus_lsu_pkg::*;
(
    input  access_size_e size_i,
    input  logic [1:0]   off_i,
    input  logic         unsigned_i,
    input  uint32        wdata_i,
    input  uint32        lo_i,
    input  uint32        hi_i,
    output logic [7:0]   mask_o,
    output logic [63:0]  wdata_o,
    output uint32        rdata_o
);

    logic [7:0]  base_mask;
    logic [31:0] data_mask;
    logic [31:0] r32;

    always_comb begin
        base_mask = 8'h01;
        data_mask = 32'h0000_00FF;
        case (size_i)
            SIZE_HALF: begin
                base_mask = 8'h03;
                data_mask = 32'h0000_FFFF;
            end
            SIZE_WORD: begin
                base_mask = 8'h0F;
                data_mask = 32'hFFFF_FFFF;
            end
            default: ;
        endcase

        mask_o  = base_mask << off_i;
        wdata_o = {32'd0, wdata_i & data_mask} << {off_i, 3'b000};

        // Only the low word of the shifted pair is ever needed.
        r32 = 32'({hi_i, lo_i} >> {off_i, 3'b000});
        case (size_i)
            SIZE_BYTE: rdata_o = unsigned_i ? {24'd0, r32[7:0]}
                                            : {{24{r32[7]}}, r32[7:0]};
            SIZE_HALF: rdata_o = unsigned_i ? {16'd0, r32[15:0]}
                                            : {{16{r32[15]}}, r32[15:0]};
            default:   rdata_o = r32;
        endcase
    end

endmodule

// File: rtl/membus_lsu.sv
// Load/store initiator: latches one request, issues one or two word accesses, returns aligned data.
module membus_lsu
    import membus_lsu_pkg::*;
#(
    parameter int unsigned WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic [WIDTH-3:0]      bus_address,
    output logic                  write_enable,
    output membus_cmd_t           membuscmd,
    input  membus_res_t           membusres
);

    localparam int unsigned WW = WIDTH - 2;

    lsu_state_e     state_q;
    logic [WIDTH-1:0] addr_q;
    logic           write_q;
    access_size_e   size_q;
    logic           unsigned_q;
    uint32          wdata_q;
    uint32          lo_hold_q;
    uint32          resp_rdata_q;

    logic [WW-1:0]  word0;
    logic [WW-1:0]  word1;
    logic           split;
    logic [7:0]     mask8;
    logic [63:0]    wdata64;
    uint32          align_rdata;
    uint32          align_lo;
    uint32          align_hi;
    logic           unused_addr;

    assign unused_addr = ^req_addr[31:WIDTH];

    assign word0 = addr_q[WIDTH-1:2];
    assign word1 = word0 + WW'(1);
    assign split = ({1'b0, addr_q[1:0]} + byte_count(size_q)) > 3'd4;

    // Split loads pair the held first word with the second; aligned loads use the bus word directly.
    assign align_lo = split ? lo_hold_q : membusres.read_data;
    assign align_hi = split ? membusres.read_data : 32'd0;

    membus_lsu_align u_align (
        .size_i     (size_q),
        .off_i      (addr_q[1:0]),
        .unsigned_i (unsigned_q),
        .wdata_i    (wdata_q),
        .lo_i       (align_lo),
        .hi_i       (align_hi),
        .mask_o     (mask8),
        .wdata_o    (wdata64),
        .rdata_o    (align_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            write_q      <= 1'b0;
            size_q       <= SIZE_BYTE;
            unsigned_q   <= 1'b0;
            wdata_q      <= '0;
            lo_hold_q    <= '0;
            resp_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q     <= req_addr[WIDTH-1:0];
                        write_q    <= req_write;
                        unsigned_q <= req_unsigned;
                        wdata_q    <= req_wdata;
                        case (req_size)
                            2'b00:   size_q <= SIZE_BYTE;
                            2'b01:   size_q <= SIZE_HALF;
                            default: size_q <= SIZE_WORD;
                        endcase
                        state_q <= ST_FIRST;
                    end
                end
                ST_FIRST: begin
                    if (split) begin
                        state_q <= ST_SECOND;
                    end else if (write_q) begin
                        resp_rdata_q <= '0;
                        state_q      <= ST_DONE;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_SECOND: begin
                    lo_hold_q <= membusres.read_data;
                    if (write_q) begin
                        resp_rdata_q <= '0;
                        state_q      <= ST_DONE;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    resp_rdata_q <= align_rdata;
                    state_q      <= ST_DONE;
                end
                ST_DONE:  state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_DONE);
    assign resp_rdata = resp_rdata_q;

    // Bus decode from state and latched fields only; reset kills the write strobe immediately.
    always_comb begin
        bus_address  = '0;
        write_enable = 1'b0;
        membuscmd    = '0;
        case (state_q)
            ST_FIRST: begin
                bus_address          = word0;
                membuscmd.mask_byte  = mask8[3:0];
                membuscmd.write_data = wdata64[31:0];
                write_enable         = write_q;
            end
            ST_SECOND: begin
                bus_address          = word1;
                membuscmd.mask_byte  = mask8[7:4];
                membuscmd.write_data = wdata64[63:32];
                write_enable         = write_q;
            end
            default: ;
        endcase
        if (rst) begin
            write_enable = 1'b0;
        end
    end

endmodule

// File: tb/tb_membus_lsu.sv
// Directed bench for membus_lsu with a registered-read memory model and a response scoreboard.
module tb_membus_lsu;
    import membus_lsu_pkg::*;

    localparam int unsigned WIDTH = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_unsigned = 1'b0;
    logic [31:0]       req_addr = 32'd0;
    logic [31:0]       req_wdata = 32'd0;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic [WIDTH-3:0]  bus_address;
    logic              write_enable;
    membus_cmd_t       membuscmd;
    membus_res_t       membusres;

    always #5 clk = ~clk;

    membus_lsu #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .bus_address  (bus_address),
        .write_enable (write_enable),
        .membuscmd    (membuscmd),
        .membusres    (membusres)
    );

    // Word memory with byte mask and one-cycle registered read.
    logic [31:0] mem [256];
    logic [31:0] rd_q = 32'd0;
    always @(posedge clk) begin
        if (write_enable)
            for (int b = 0; b < 4; b++)
                if (membuscmd.mask_byte[b])
                    mem[bus_address][8*b +: 8] <= membuscmd.write_data[8*b +: 8];
        rd_q <= mem[bus_address];
    end
    assign membusres.read_data = rd_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   acc_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Handshake and response monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst && req_valid && req_ready)
            acc_q.push_back(cyc);
        if (resp_valid) begin
            exp_t e;
            int   a;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_resp: got resp_valid 1 expected 0");
            end else begin
                e = sb.pop_front();
                a = (acc_q.size() != 0) ? acc_q.pop_front() : -1000;
                check("resp_rdata", resp_rdata, e.data);
                check("latency", 32'(cyc - a), 32'(e.lat));
            end
        end
    end

    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp, input int lat, input bit push);
        if (push) sb.push_back('{exp, lat});
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 30; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("sb_drained", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_bus(input string tag, input logic [31:0] a, input logic [3:0] m,
                             input logic [31:0] d, input logic we);
        check({tag, "_addr"}, 32'(bus_address), a);
        check({tag, "_mask"}, 32'(membuscmd.mask_byte), 32'(m));
        check({tag, "_wdata"}, membuscmd.write_data, d);
        check({tag, "_we"}, 32'(write_enable), 32'(we));
    endtask

    initial begin
        int cnt;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check_bus("rst", 32'd0, 4'b0000, 32'd0, 1'b0);
        rst = 1'b0;

        // Byte store then signed byte load
        do_req(1'b1, 2'b00, 1'b0, 32'h005, 32'h0000_00AB, 32'd0, 2, 1'b1);
        check_bus("sb_first", 32'd1, 4'b0010, 32'h0000_AB00, 1'b1);
        check("sb_ready_busy", 32'(req_ready), 32'd0);
        wait_done();
        do_req(1'b0, 2'b00, 1'b0, 32'h005, 32'd0, 32'hFFFF_FFAB, 3, 1'b1);
        check_bus("lb_first", 32'd1, 4'b0010, 32'd0, 1'b0);
        wait_done();

        // Split word store then load
        do_req(1'b1, 2'b10, 1'b0, 32'h006, 32'h1122_3344, 32'd0, 3, 1'b1);
        check_bus("sw_acc1", 32'd1, 4'b1100, 32'h3344_0000, 1'b1);
        @(posedge clk);
        #1;
        check_bus("sw_acc2", 32'd2, 4'b0011, 32'h0000_1122, 1'b1);
        wait_done();
        do_req(1'b0, 2'b10, 1'b0, 32'h006, 32'd0, 32'h1122_3344, 4, 1'b1);
        wait_done();

        // Split half load across bytes 3 and 4
        do_req(1'b1, 2'b00, 1'b0, 32'h003, 32'h0000_0080, 32'd0, 2, 1'b1);
        wait_done();
        do_req(1'b1, 2'b00, 1'b0, 32'h004, 32'h0000_00FF, 32'd0, 2, 1'b1);
        wait_done();
        do_req(1'b0, 2'b01, 1'b1, 32'h003, 32'd0, 32'h0000_FF80, 4, 1'b1);
        wait_done();
        do_req(1'b0, 2'b01, 1'b0, 32'h003, 32'd0, 32'hFFFF_FF80, 4, 1'b1);
        wait_done();

        // Half store at the top byte wraps to word 0
        do_req(1'b1, 2'b01, 1'b0, 32'h3FF, 32'h0000_BEEF, 32'd0, 3, 1'b1);
        check_bus("wrap_acc1", 32'hFF, 4'b1000, 32'hEF00_0000, 1'b1);
        @(posedge clk);
        #1;
        check_bus("wrap_acc2", 32'd0, 4'b0001, 32'h0000_00BE, 1'b1);
        wait_done();
        do_req(1'b0, 2'b01, 1'b1, 32'h3FF, 32'd0, 32'h0000_BEEF, 4, 1'b1);
        wait_done();

        // Reset in the second access of a split store
        do_req(1'b1, 2'b10, 1'b0, 32'h040, 32'hCAFE_F00D, 32'd0, 2, 1'b1);
        wait_done();
        do_req(1'b1, 2'b10, 1'b0, 32'h03E, 32'h5566_7788, 32'd0, 0, 1'b0);
        check_bus("abort_acc1", 32'h0F, 4'b1100, 32'h7788_0000, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_we", 32'(write_enable), 32'd0);
        check("abort_addr2", 32'(bus_address), 32'h10);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_ready", 32'(req_ready), 32'd1);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        acc_q.delete();
        do_req(1'b0, 2'b10, 1'b0, 32'h040, 32'd0, 32'hCAFE_F00D, 3, 1'b1);
        wait_done();
        do_req(1'b0, 2'b01, 1'b1, 32'h03E, 32'd0, 32'h0000_7788, 3, 1'b1);
        wait_done();

        // Back-to-back loads with req_valid held high
        sb.push_back('{32'hCAFE_F00D, 3});
        sb.push_back('{32'h0000_3344, 3});
        req_write    = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h040;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_size     = 2'b01;
        req_unsigned = 1'b1;
        req_addr     = 32'h006;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready) break;
            cnt++;
        end
        check("b2b_busy_cycles", 32'(cnt), 32'd3);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
